robo_controller: RTL

- Robot-side controller for the maze environment. It reads the environment's sensor outputs (head, left, under, barrier) and issues the movement commands the environment consumes (avancar, girar, remover).
- It implements a left-hand wall follower with barrier demolition, goal detection and stuck detection.
- It is clocked by the environment's clock_out, so it runs at the same manual or free-running rate as the map.

---
 rtl/robo_pkg.sv | 37 +++
 rtl/robo_controller_sat_counter.sv | 31 +++
 rtl/robo_controller.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/robo_pkg.sv
// Shared definitions for the maze robot controller and the maze environment.
//   state_t        : controller FSM states
//   CELL_*         : map cell codes used by the environment
//   DIR_*          : robot orientation codes
//   TURN_R_PULSES  : left-turn pulses that make one net right turn
package robo_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_DECIDE,
    S_FWD,
    S_TURN_L,
    S_TURN_R,
    S_REMOVE,
    S_WAIT,
    S_DONE,
    S_STUCK
  } state_t;

  localparam int unsigned CELL_W = 3;
  localparam logic [CELL_W-1:0] CELL_WALL     = 3'd0;
  localparam logic [CELL_W-1:0] CELL_PATH     = 3'd1;
  localparam logic [CELL_W-1:0] CELL_BARRIER3 = 3'd2;
  localparam logic [CELL_W-1:0] CELL_BARRIER6 = 3'd3;
  localparam logic [CELL_W-1:0] CELL_BARRIER9 = 3'd4;
  localparam logic [CELL_W-1:0] CELL_BLACK    = 3'd7;

  localparam int unsigned DIR_W = 2;
  localparam logic [DIR_W-1:0] DIR_NORTH = 2'd0;
  localparam logic [DIR_W-1:0] DIR_WEST  = 2'd1;
  localparam logic [DIR_W-1:0] DIR_SOUTH = 2'd2;
  localparam logic [DIR_W-1:0] DIR_EAST  = 2'd3;

  localparam int unsigned TURN_R_PULSES = 3;
  localparam int unsigned PULSE_W       = 2;

endpackage

// File: rtl/robo_controller_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clock, reset : clock and synchronous active-high reset
//   clear        : synchronous clear to zero (wins over inc)
//   inc          : increment by one unless saturated
//   count        : registered count value
//   sat_c        : combinational flag, count is all-ones
module sat_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic             sat_c
);

  assign sat_c = &count;

  // Holds at all-ones instead of wrapping.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && !sat_c) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/robo_controller.sv
// Left-hand wall follower for the maze robot, with barrier demolition,
// goal detection and stuck detection. Runs on the environment's clock.
//   clock, reset     : clock and synchronous active-high reset
//   enable           : run gate, controller idles while low
//   head, left       : wall/edge ahead, wall/edge on the left
//   under, barrier   : standing on goal cell, barrier ahead
//   avancar, girar   : one-cycle move-forward / rotate-left pulses
//   remover          : held while demolishing the barrier ahead
//   done, stuck      : sticky terminal flags
//   move_count       : forward moves issued since reset (saturating)
module robo_controller
  import robo_pkg::*;
#(
  parameter int unsigned MOVE_W          = 10,
  parameter int unsigned MAX_MOVES       = 1000,
  parameter int unsigned REMOVE_TIMEOUT  = 12,
  parameter int unsigned MAX_RIGHT_TURNS = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              head,
  input  logic              left,
  input  logic              under,
  input  logic              barrier,
  output logic              avancar,
  output logic              girar,
  output logic              remover,
  output logic              done,
  output logic              stuck,
  output logic [MOVE_W-1:0] move_count
);

  localparam int unsigned RM_W = $clog2(REMOVE_TIMEOUT + 1);
  localparam int unsigned RT_W = $clog2(MAX_RIGHT_TURNS + 1);

  state_t             state;
  state_t             state_next;
  logic [PULSE_W-1:0] pulse_cnt;
  logic               turned_left;
  logic [RM_W-1:0]    rm_count;
  logic [RT_W-1:0]    rt_count;
  logic               move_sat_c;
  logic               rm_sat_c;
  logic               rt_sat_c;
  logic               pulse_last;
  logic               move_at_limit;
  logic               rm_at_limit;
  logic               rt_at_limit;
  logic               avancar_d;
  logic               girar_d;
  logic               remover_d;
  logic               done_d;
  logic               stuck_d;

  // Limits are checked against the value the counter is about to take.
  assign pulse_last    = (pulse_cnt == PULSE_W'(TURN_R_PULSES - 1));
  assign move_at_limit = move_sat_c || (move_count >= MOVE_W'(MAX_MOVES - 1));
  assign rm_at_limit   = rm_sat_c || (rm_count >= RM_W'(REMOVE_TIMEOUT - 1));
  assign rt_at_limit   = rt_sat_c || (rt_count >= RT_W'(MAX_RIGHT_TURNS - 1));

  sat_counter #(.WIDTH(MOVE_W)) u_move_cnt (
    .clock (clock),
    .reset (reset),
    .clear (1'b0),
    .inc   (state == S_FWD),
    .count (move_count),
    .sat_c (move_sat_c)
  );

  // Remove timer restarts on every decision so each barrier gets a full budget.
  sat_counter #(.WIDTH(RM_W)) u_rm_cnt (
    .clock (clock),
    .reset (reset),
    .clear (state == S_DECIDE),
    .inc   (state == S_REMOVE),
    .count (rm_count),
    .sat_c (rm_sat_c)
  );

  sat_counter #(.WIDTH(RT_W)) u_rt_cnt (
    .clock (clock),
    .reset (reset),
    .clear (state == S_FWD),
    .inc   ((state == S_TURN_R) && pulse_last),
    .count (rt_count),
    .sat_c (rt_sat_c)
  );

  // State, registered commands, turn pulse counter and turned_left flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      avancar     <= 1'b0;
      girar       <= 1'b0;
      remover     <= 1'b0;
      done        <= 1'b0;
      stuck       <= 1'b0;
      pulse_cnt   <= '0;
      turned_left <= 1'b0;
    end else begin
      state   <= state_next;
      avancar <= avancar_d;
      girar   <= girar_d;
      remover <= remover_d;
      done    <= done_d;
      stuck   <= stuck_d;

      if ((state == S_TURN_R) && !pulse_last) begin
        pulse_cnt <= pulse_cnt + PULSE_W'(1);
      end else begin
        pulse_cnt <= '0;
      end

      if (state == S_TURN_L) begin
        turned_left <= 1'b1;
      end else if ((state == S_FWD) || (state == S_TURN_R)) begin
        turned_left <= 1'b0;
      end
    end
  end

  // Next state; commands are decoded from the next state so they are
  // registered and line up with the cycle the FSM spends in that state.
  always_comb begin
    state_next = state;
    avancar_d  = 1'b0;
    girar_d    = 1'b0;
    remover_d  = 1'b0;
    done_d     = 1'b0;
    stuck_d    = 1'b0;

    case (state)
      S_IDLE: begin
        if (enable) state_next = S_DECIDE;
      end
      S_DECIDE: begin
        if (!enable)                     state_next = S_IDLE;
        else if (under)                  state_next = S_DONE;
        else if (barrier)                state_next = S_REMOVE;
        else if (turned_left && !head)   state_next = S_FWD;
        else if (!turned_left && !left)  state_next = S_TURN_L;
        else if (!head)                  state_next = S_FWD;
        else                             state_next = S_TURN_R;
      end
      S_FWD: begin
        state_next = move_at_limit ? S_STUCK : S_WAIT;
      end
      S_TURN_L: begin
        state_next = S_WAIT;
      end
      S_TURN_R: begin
        if (pulse_last) state_next = rt_at_limit ? S_STUCK : S_WAIT;
      end
      S_REMOVE: begin
        if (!barrier)         state_next = S_WAIT;
        else if (rm_at_limit) state_next = S_STUCK;
      end
      S_WAIT: begin
        // A disable takes effect here, after any multi-cycle command ends.
        state_next = enable ? S_DECIDE : S_IDLE;
      end
      S_DONE:  state_next = S_DONE;
      S_STUCK: state_next = S_STUCK;
      default: state_next = S_IDLE;
    endcase

    avancar_d = (state_next == S_FWD);
    girar_d   = (state_next == S_TURN_L) || (state_next == S_TURN_R);
    remover_d = (state_next == S_REMOVE);
    done_d    = (state_next == S_DONE);
    stuck_d   = (state_next == S_STUCK);
  end

endmodule
